// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      StHdr,
      StData,
      StCsum,
      StDone,
      StErr
   } state_e;

   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Little-endian 8-to-32 packer; word_valid_o pulses combinationally with the last byte of a word.
module byte_packer
   import instr_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam int unsigned CntW = $clog2(WORD_BYTES);

   logic [CntW-1:0] cnt_q;
   logic [31:0]     shift_q;

   // Newest byte enters at the top, so after four bytes the first one sits at [7:0].
   assign word_o       = {byte_i, shift_q[31:8]};
   assign word_valid_o = byte_en_i && (cnt_q == CntW'(WORD_BYTES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (byte_en_i) begin
         cnt_q   <= cnt_q + 1'b1;
         shift_q <= word_o;
      end
   end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses header/payload/checksum byte stream and writes instruction memory,
// holding the CPU in reset until a checksummed image is in place.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned INSTR_NUM_BITS_WIDTH = 20
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        wr_en_o,
   output logic [31:0] wr_addr_o,
   output logic [31:0] wr_data_o,
   output logic        cpu_hold_o,
   output logic        load_done_o,
   output logic        load_err_o
);

   localparam int unsigned IdxW     = INSTR_NUM_BITS_WIDTH + 1;
   localparam logic [32:0] MaxWords = 33'(1) << INSTR_NUM_BITS_WIDTH;

   state_e          state_q, state_d;
   logic [31:0]     n_q, n_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [7:0]      csum_q, csum_d;
   logic            wr_en_q, wr_en_d;
   logic [31:0]     wr_addr_q, wr_addr_d;
   logic [31:0]     wr_data_q, wr_data_d;

   logic            accept;
   logic            pack_en;
   logic            word_valid;
   logic [31:0]     word;

   assign accept  = byte_valid_i && byte_ready_o;
   assign pack_en = accept && ((state_q == StHdr) || (state_q == StData));

   byte_packer u_byte_packer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_en_i    (pack_en),
      .byte_i       (byte_data_i),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      idx_d     = idx_q;
      csum_d    = csum_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      unique case (state_q)
         StHdr: begin
            if (word_valid) begin
               n_d = word;
               if ({1'b0, word} > MaxWords) begin
                  state_d = StErr;
               end else if (word == '0) begin
                  state_d = StCsum;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               csum_d = csum_q ^ byte_data_i;
            end
            if (word_valid) begin
               wr_en_d   = 1'b1;
               wr_addr_d = 32'(idx_q) << 2;
               wr_data_d = word;
               idx_d     = idx_q + 1'b1;
               if (32'(idx_d) == n_q) begin
                  state_d = StCsum;
               end
            end
         end
         StCsum: begin
            if (accept) begin
               state_d = (byte_data_i == csum_q) ? StDone : StErr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StHdr;
         n_q       <= '0;
         idx_q     <= '0;
         csum_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign byte_ready_o = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign cpu_hold_o   = (state_q != StDone);
   assign load_done_o  = (state_q == StDone);
   assign load_err_o   = (state_q == StErr);

endmodule
